xbox_mem_responder: RTL and testbench
=====================================

Name: xbox_mem_responder

Overview:
- Responder end of the XBOX accelerator memory interface. Holds NUM_MEMS line-organised SRAM banks and answers accelerator-mastered reads and byte-enabled writes with fixed 1-cycle read latency.
- Provides a secondary host/DMA port that gets each bank only while the accelerator does not own it. The host uses this port to preload operands and fetch results around an accelerator run.

Parameters:
- NUM_MEMS, 2, number of independent memory banks.
- LOG2_LINES_PER_MEM, 8, address width per bank; each bank holds 2**LOG2_LINES_PER_MEM lines of 256 bits (8 words x 32 bits, 32 bytes).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset (asserted when 0).
- xlr_mem_addr  in  [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0]  accelerator line address per bank.
- xlr_mem_wdata  in  [NUM_MEMS-1:0][7:0][31:0]  accelerator write line per bank.
- xlr_mem_be  in  [NUM_MEMS-1:0][31:0]  byte enables; bit b covers bits 8b+7:8b of the line.
- xlr_mem_rd  in  [NUM_MEMS-1:0]  read strobe per bank.
- xlr_mem_wr  in  [NUM_MEMS-1:0]  write strobe per bank.
- xlr_mem_rdata  out  [NUM_MEMS-1:0][7:0][31:0]  registered read line per bank.
- xlr_owns  in  [NUM_MEMS-1:0]  bank ownership; 1 means the accelerator owns the bank.
- host_mem_req  in  1  host access request.
- host_mem_id  in  $clog2(NUM_MEMS)  target bank.
- host_mem_wr  in  1  1 = write, 0 = read.
- host_mem_addr  in  LOG2_LINES_PER_MEM  host line address.
- host_mem_wdata  in  [7:0][31:0]  host write line.
- host_mem_be  in  32  host byte enables.
- host_mem_gnt  out  1  combinational grant.
- host_mem_rvalid  out  1  host read data valid.
- host_mem_rdata  out  [7:0][31:0]  host read line.
- xlr_viol_cnt  out  16  saturating count of dropped accelerator accesses.

Behaviour:
- Reset values:
  - xlr_mem_rdata, host_mem_rdata, host_mem_rvalid and xlr_viol_cnt reset to 0.
  - Storage arrays are not reset. Their content after rst_n is undefined on the first cycle and retained on later resets.
- Accelerator path, per bank m, when xlr_owns[m]=1:
  - Write: wr[m] at edge N updates only the bytes whose be bit is set. be=0 with wr=1 is a no-op.
  - Read: rd[m] at edge N loads xlr_mem_rdata[m] at edge N, so data is visible in cycle N+1.
  - xlr_mem_rdata[m] holds its last value until the next rd[m].
  - rd and wr in the same cycle to the same address: read returns the pre-write (old) data, and the write commits.
- Accelerator path when xlr_owns[m]=0:
  - rd[m] and wr[m] are dropped. Storage and xlr_mem_rdata[m] are unchanged.
  - xlr_viol_cnt increments by the number of banks violating that cycle and saturates at 16'hFFFF.
- Host path:
  - host_mem_gnt = host_mem_req & ~xlr_owns[host_mem_id]. An ungranted request is stalled, not dropped; the host must hold the request.
  - Granted write: same byte-enable rule as the accelerator path.
  - Granted read at edge N: host_mem_rvalid=1 in cycle N+1 only, and host_mem_rdata is loaded and held.
  - An out-of-range host_mem_id (when NUM_MEMS is not a power of 2) gives gnt=0.
- Ownership and conflicts:
  - An ownership change takes effect in the same cycle.
  - A host read granted in cycle N completes in N+1 even if ownership flips in N+1.
  - Accelerator and host can never access the same bank in the same cycle. Different banks run fully in parallel.
- Reset mid-operation: in-flight reads are discarded (rvalid=0, rdata=0). Writes committed before reset persist.
- No FSM per bank. The sequential state is the storage array, the registered rdata, a 1-bit host-read pipeline flag, and the violation counter.

Optional Feature:
- Macro: XBOX_MEM_PARITY_EN.
- When defined:
  - Each bank also stores 32 even-parity bits per line, one per byte, updated together with each written byte.
  - Extra input par_inj (1): when set during a write, the stored parity of the written bytes is inverted.
  - Extra output xlr_par_err [NUM_MEMS-1:0]: registered alongside xlr_mem_rdata, pulses 1 for one cycle when any read byte mismatches its stored parity.
  - Extra output host_par_err (1): same rule, aligned with host_mem_rvalid.
  - Error outputs reset to 0.
- When undefined: no parity storage and no extra ports.

Decomposition:
- Package xbox_mem_pkg holds:
  - BYTES_PER_LINE=32, WORDS_PER_LINE=8, WORD_W=32.
  - typedef line_t (logic [7:0][31:0]) and be_t (logic [31:0]).
  - Function apply_be(old, new, be) returning the merged line.
- Sub-module xbox_mem_bank: a single 2-port-muxed bank with byte-enable write, registered read, and parity under the macro. It is instantiated NUM_MEMS times by generate. Arbitration and the counter stay in the top level.

Test Plan:
- Write and readback: owns[0]=1; wr addr 0x05, be=FFFFFFFF, wdata words 1..8. Then rd addr 0x05. Required: xlr_mem_rdata[0] = 1..8 exactly one cycle after rd; value held for 5 idle cycles.
- Partial byte enable: line 0x05 = 1..8; write be=0000000F with word0=0xDEADBEEF. Required: readback word0=0xDEADBEEF, words 1..7 unchanged.
- Read-during-write: same-cycle rd and wr to 0x02, old line A, new line B. Required: rdata = A; the following rd returns B.
- Host arbitration: owns[1]=1 with host read of bank 1. Required: gnt=0 and rvalid stays 0. Drop owns[1]: gnt=1 that cycle and rvalid=1 the next cycle with correct data.
- Violation counter:
  - owns=0 and accelerator wr to bank 0. Required: storage unchanged and xlr_viol_cnt=1.
  - Both banks violate in one cycle. Required: count += 2.
  - Saturation check from 16'hFFFE.
- Reset mid-read: rd, then assert rst_n=0 before the next edge. Required: rdata=0 and rvalid=0. After reset, the previously written line reads back intact. With parity enabled: par_inj write then read gives xlr_par_err=1 for one cycle.

Source files
------------

// File: rtl/xbox_mem_pkg.sv
// Shared line/byte-enable types and the byte-merge helper for the XBOX memory responder.
package xbox_mem_pkg;

  localparam int BYTES_PER_LINE = 32;
  localparam int WORDS_PER_LINE = 8;
  localparam int WORD_W         = 32;

  typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_t;
  typedef logic [BYTES_PER_LINE-1:0]             be_t;

  function automatic line_t apply_be(line_t old_line, line_t new_line, be_t be);
    logic [BYTES_PER_LINE*8-1:0] o_flat;
    logic [BYTES_PER_LINE*8-1:0] n_flat;
    logic [BYTES_PER_LINE*8-1:0] r_flat;
    o_flat = old_line;
    n_flat = new_line;
    r_flat = o_flat;
    for (int b = 0; b < BYTES_PER_LINE; b++) begin
      if (be[b]) r_flat[8*b +: 8] = n_flat[8*b +: 8];
    end
    return line_t'(r_flat);
  endfunction

  // One even-parity bit per byte: the XOR of that byte's bits.
  function automatic be_t line_parity(line_t line);
    logic [BYTES_PER_LINE*8-1:0] flat;
    be_t par;
    flat = line;
    for (int b = 0; b < BYTES_PER_LINE; b++) par[b] = ^flat[8*b +: 8];
    return par;
  endfunction

endpackage

// File: rtl/xbox_mem_responder_if.sv
// Accelerator and host memory bus bundle for xbox_mem_responder.
// Carries the parity signals only when XBOX_MEM_PARITY_EN is defined.
interface xbox_mem_responder_if #(
  parameter int NUM_MEMS           = 2,
  parameter int LOG2_LINES_PER_MEM = 8
);
  localparam int ID_W = (NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1;

  logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0] xlr_mem_addr;
  logic [NUM_MEMS-1:0][7:0][31:0]              xlr_mem_wdata;
  logic [NUM_MEMS-1:0][31:0]                   xlr_mem_be;
  logic [NUM_MEMS-1:0]                         xlr_mem_rd;
  logic [NUM_MEMS-1:0]                         xlr_mem_wr;
  logic [NUM_MEMS-1:0][7:0][31:0]              xlr_mem_rdata;
  logic [NUM_MEMS-1:0]                         xlr_owns;

  logic                          host_mem_req;
  logic [ID_W-1:0]               host_mem_id;
  logic                          host_mem_wr;
  logic [LOG2_LINES_PER_MEM-1:0] host_mem_addr;
  logic [7:0][31:0]              host_mem_wdata;
  logic [31:0]                   host_mem_be;
  logic                          host_mem_gnt;
  logic                          host_mem_rvalid;
  logic [7:0][31:0]              host_mem_rdata;

  logic [15:0] xlr_viol_cnt;

`ifdef XBOX_MEM_PARITY_EN
  logic                par_inj;
  logic [NUM_MEMS-1:0] xlr_par_err;
  logic                host_par_err;
`endif

  modport slave (
    input  xlr_mem_addr, xlr_mem_wdata, xlr_mem_be, xlr_mem_rd, xlr_mem_wr, xlr_owns,
    input  host_mem_req, host_mem_id, host_mem_wr, host_mem_addr, host_mem_wdata, host_mem_be,
    output xlr_mem_rdata, host_mem_gnt, host_mem_rvalid, host_mem_rdata, xlr_viol_cnt
`ifdef XBOX_MEM_PARITY_EN
    , input par_inj
    , output xlr_par_err, host_par_err
`endif
  );

  modport master (
    output xlr_mem_addr, xlr_mem_wdata, xlr_mem_be, xlr_mem_rd, xlr_mem_wr, xlr_owns,
    output host_mem_req, host_mem_id, host_mem_wr, host_mem_addr, host_mem_wdata, host_mem_be,
    input  xlr_mem_rdata, host_mem_gnt, host_mem_rvalid, host_mem_rdata, xlr_viol_cnt
`ifdef XBOX_MEM_PARITY_EN
    , output par_inj
    , input xlr_par_err, host_par_err
`endif
  );

endinterface

// File: rtl/xbox_mem_bank.sv
// One SRAM bank: a single port muxed between accelerator (when owned) and host,
// byte-enable writes, registered reads per side. Parity under XBOX_MEM_PARITY_EN.
module xbox_mem_bank
  import xbox_mem_pkg::*;
#(
  parameter int LOG2_LINES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  xlr_sel,
  input  logic                  xlr_rd,
  input  logic                  xlr_wr,
  input  logic [LOG2_LINES-1:0] xlr_addr,
  input  line_t                 xlr_wdata,
  input  be_t                   xlr_be,
  output line_t                 xlr_rdata,
  input  logic                  host_rd,
  input  logic                  host_wr,
  input  logic [LOG2_LINES-1:0] host_addr,
  input  line_t                 host_wdata,
  input  be_t                   host_be,
  output line_t                 host_rdata
`ifdef XBOX_MEM_PARITY_EN
  ,
  input  logic                  par_inj,
  output logic                  xlr_par_err,
  output logic                  host_par_err
`endif
);

  localparam int LINES = 2 ** LOG2_LINES;

  line_t mem [LINES];

  logic                  wr_en;
  logic                  xlr_rd_en;
  logic                  host_rd_en;
  logic [LOG2_LINES-1:0] addr;
  line_t                 wdata;
  be_t                   be;

  // Ownership picks the single physical port; the two sides never overlap.
  always_comb begin
    addr       = xlr_sel ? xlr_addr  : host_addr;
    wdata      = xlr_sel ? xlr_wdata : host_wdata;
    be         = xlr_sel ? xlr_be    : host_be;
    wr_en      = xlr_sel ? xlr_wr    : host_wr;
    xlr_rd_en  = xlr_sel & xlr_rd;
    host_rd_en = ~xlr_sel & host_rd;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= apply_be(mem[addr], wdata, be);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xlr_rdata  <= '0;
      host_rdata <= '0;
    end else begin
      if (xlr_rd_en)  xlr_rdata  <= mem[addr];
      if (host_rd_en) host_rdata <= mem[addr];
    end
  end

`ifdef XBOX_MEM_PARITY_EN
  be_t  par_mem [LINES];
  be_t  par_new;
  logic rd_err;

  always_comb begin
    par_new = line_parity(wdata) ^ {BYTES_PER_LINE{par_inj}};
    rd_err  = |(line_parity(mem[addr]) ^ par_mem[addr]);
  end

  always_ff @(posedge clk) begin
    if (wr_en) par_mem[addr] <= (par_mem[addr] & ~be) | (par_new & be);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xlr_par_err  <= 1'b0;
      host_par_err <= 1'b0;
    end else begin
      xlr_par_err  <= xlr_rd_en & rd_err;
      host_par_err <= host_rd_en & rd_err;
    end
  end
`endif

endmodule

// File: rtl/xbox_mem_responder.sv
// XBOX memory responder: NUM_MEMS banks, accelerator-owned or host-accessible,
// with a saturating count of dropped accelerator accesses. Parity via XBOX_MEM_PARITY_EN.
module xbox_mem_responder
  import xbox_mem_pkg::*;
#(
  parameter int NUM_MEMS           = 2,
  parameter int LOG2_LINES_PER_MEM = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  xbox_mem_responder_if.slave  bus
);

  localparam int ID_W = (NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1;

  logic                id_ok;
  logic                gnt;
  logic [NUM_MEMS-1:0] host_rd_sel;
  logic [NUM_MEMS-1:0] host_wr_sel;
  logic [NUM_MEMS-1:0] viol;
  logic [16:0]         cnt_sum;
  logic [15:0]         cnt_q;
  logic                rd_pend_q;
  logic [ID_W-1:0]     rd_id_q;
  line_t               xlr_rdata_w  [NUM_MEMS];
  line_t               host_rdata_w [NUM_MEMS];

  generate
    if ((1 << ID_W) == NUM_MEMS) begin : g_id_full
      assign id_ok = 1'b1;
    end else begin : g_id_range
      assign id_ok = int'(bus.host_mem_id) < NUM_MEMS;
    end
  endgenerate

  always_comb begin
    gnt         = 1'b0;
    host_rd_sel = '0;
    host_wr_sel = '0;
    if (bus.host_mem_req && id_ok) gnt = ~bus.xlr_owns[bus.host_mem_id];
    for (int m = 0; m < NUM_MEMS; m++) begin
      if (gnt && int'(bus.host_mem_id) == m) begin
        host_rd_sel[m] = ~bus.host_mem_wr;
        host_wr_sel[m] = bus.host_mem_wr;
      end
    end
  end

  assign bus.host_mem_gnt = gnt;

  always_comb begin
    viol    = ~bus.xlr_owns & (bus.xlr_mem_rd | bus.xlr_mem_wr);
    cnt_sum = {1'b0, cnt_q};
    for (int m = 0; m < NUM_MEMS; m++) cnt_sum = cnt_sum + 17'(viol[m]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_id_q   <= '0;
    end else begin
      cnt_q     <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
      rd_pend_q <= gnt & ~bus.host_mem_wr;
      if (gnt && !bus.host_mem_wr) rd_id_q <= bus.host_mem_id;
    end
  end

  assign bus.xlr_viol_cnt    = cnt_q;
  assign bus.host_mem_rvalid = rd_pend_q;
  // Each bank holds its own host read register; rd_id_q selects the last one read.
  assign bus.host_mem_rdata  = host_rdata_w[rd_id_q];

`ifdef XBOX_MEM_PARITY_EN
  logic [NUM_MEMS-1:0] xlr_perr_w;
  logic [NUM_MEMS-1:0] host_perr_w;
  assign bus.xlr_par_err  = xlr_perr_w;
  assign bus.host_par_err = rd_pend_q & host_perr_w[rd_id_q];
`endif

  generate
    for (genvar m = 0; m < NUM_MEMS; m++) begin : g_bank
      xbox_mem_bank #(.LOG2_LINES(LOG2_LINES_PER_MEM)) u_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .xlr_sel    (bus.xlr_owns[m]),
        .xlr_rd     (bus.xlr_mem_rd[m]),
        .xlr_wr     (bus.xlr_mem_wr[m]),
        .xlr_addr   (bus.xlr_mem_addr[m]),
        .xlr_wdata  (bus.xlr_mem_wdata[m]),
        .xlr_be     (bus.xlr_mem_be[m]),
        .xlr_rdata  (xlr_rdata_w[m]),
        .host_rd    (host_rd_sel[m]),
        .host_wr    (host_wr_sel[m]),
        .host_addr  (bus.host_mem_addr),
        .host_wdata (bus.host_mem_wdata),
        .host_be    (bus.host_mem_be),
        .host_rdata (host_rdata_w[m])
`ifdef XBOX_MEM_PARITY_EN
        ,
        .par_inj      (bus.par_inj),
        .xlr_par_err  (xlr_perr_w[m]),
        .host_par_err (host_perr_w[m])
`endif
      );
      assign bus.xlr_mem_rdata[m] = xlr_rdata_w[m];
    end
  endgenerate

endmodule

// File: tb/tb_xbox_mem_responder.sv
// Directed bench for xbox_mem_responder: vector table on bank 0 plus hand-written
// arbitration, violation-counter, reset and (XBOX_MEM_PARITY_EN) parity sequences.
module tb_xbox_mem_responder;
  import xbox_mem_pkg::*;

  localparam int NM = 2;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xbox_mem_responder_if #(.NUM_MEMS(NM), .LOG2_LINES_PER_MEM(LW)) bus ();

  xbox_mem_responder #(.NUM_MEMS(NM), .LOG2_LINES_PER_MEM(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    be_t        be;
    line_t      wdata;
    logic       chk;
    line_t      exp;
  } vec_t;

  vec_t vecs [11];

  function automatic line_t mk_line(logic [31:0] base);
    line_t l;
    for (int i = 0; i < 8; i++) l[i] = base + 32'(i);
    return l;
  endfunction

  function automatic vec_t mkv(logic rd, logic wr, logic [7:0] addr, be_t be,
                               line_t wdata, logic chk, line_t exp);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.be = be;
    v.wdata = wdata; v.chk = chk; v.exp = exp;
    return v;
  endfunction

  task automatic chk_line(string name, line_t act, line_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_val(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.xlr_mem_rd     = '0;
    bus.xlr_mem_wr     = '0;
    bus.host_mem_req   = 1'b0;
    bus.host_mem_wr    = 1'b0;
`ifdef XBOX_MEM_PARITY_EN
    bus.par_inj        = 1'b0;
`endif
  endtask

  line_t l18, la, lb, lc, ld, lp, lw2, lb2, zero_line;

  initial begin
    zero_line = '0;
    l18 = mk_line(32'h0000_0001);
    la  = mk_line(32'hA000_0000);
    lb  = mk_line(32'hB000_0000);
    lc  = mk_line(32'hC000_0000);
    ld  = mk_line(32'hD000_0000);
    lw2 = {8{32'hFFFF_FFFF}};
    lw2[0] = 32'hDEAD_BEEF;
    lp  = l18;
    lp[0] = 32'hDEAD_BEEF;
    lb2 = lb;
    lb2[1] = 32'hC000_0001;

    vecs[0]  = mkv(1'b0, 1'b1, 8'h05, 32'hFFFF_FFFF, l18,       1'b0, zero_line);
    vecs[1]  = mkv(1'b1, 1'b0, 8'h05, 32'h0,         zero_line, 1'b1, l18);
    vecs[2]  = mkv(1'b0, 1'b1, 8'h05, 32'h0000_000F, lw2,       1'b0, zero_line);
    vecs[3]  = mkv(1'b1, 1'b0, 8'h05, 32'h0,         zero_line, 1'b1, lp);
    vecs[4]  = mkv(1'b0, 1'b1, 8'h02, 32'hFFFF_FFFF, la,        1'b0, zero_line);
    vecs[5]  = mkv(1'b1, 1'b1, 8'h02, 32'hFFFF_FFFF, lb,        1'b1, la);
    vecs[6]  = mkv(1'b1, 1'b0, 8'h02, 32'h0,         zero_line, 1'b1, lb);
    vecs[7]  = mkv(1'b0, 1'b1, 8'h02, 32'h0,         lc,        1'b0, zero_line);
    vecs[8]  = mkv(1'b1, 1'b0, 8'h02, 32'h0,         zero_line, 1'b1, lb);
    vecs[9]  = mkv(1'b0, 1'b1, 8'h02, 32'h0000_00C0, lc,        1'b0, zero_line);
    vecs[10] = mkv(1'b1, 1'b0, 8'h02, 32'h0,         zero_line, 1'b1, lb2);

    idle();
    bus.xlr_owns       = '0;
    bus.xlr_mem_addr   = '0;
    bus.xlr_mem_wdata  = '0;
    bus.xlr_mem_be     = '0;
    bus.host_mem_id    = '0;
    bus.host_mem_addr  = '0;
    bus.host_mem_wdata = '0;
    bus.host_mem_be    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_line("rst_xlr_rdata0", bus.xlr_mem_rdata[0], zero_line);
    chk_line("rst_xlr_rdata1", bus.xlr_mem_rdata[1], zero_line);
    chk_line("rst_host_rdata", bus.host_mem_rdata, zero_line);
    chk_val("rst_rvalid", 32'(bus.host_mem_rvalid), 32'd0);
    chk_val("rst_viol_cnt", 32'(bus.xlr_viol_cnt), 32'd0);
    rst_n = 1'b1;

    bus.xlr_owns = 2'b01;
    for (int i = 0; i < 11; i++) begin
      bus.xlr_mem_rd[0]    = vecs[i].rd;
      bus.xlr_mem_wr[0]    = vecs[i].wr;
      bus.xlr_mem_addr[0]  = vecs[i].addr;
      bus.xlr_mem_be[0]    = vecs[i].be;
      bus.xlr_mem_wdata[0] = vecs[i].wdata;
      step();
      if (vecs[i].chk) chk_line($sformatf("vec%0d", i), bus.xlr_mem_rdata[0], vecs[i].exp);
    end
    idle();
    for (int k = 0; k < 5; k++) begin
      step();
      chk_line($sformatf("hold%0d", k), bus.xlr_mem_rdata[0], lb2);
    end

    // Host write to a free bank, then a read stalled by accelerator ownership.
    bus.host_mem_req   = 1'b1;
    bus.host_mem_id    = 1'b1;
    bus.host_mem_wr    = 1'b1;
    bus.host_mem_addr  = 8'h10;
    bus.host_mem_wdata = ld;
    bus.host_mem_be    = 32'hFFFF_FFFF;
    #1;
    chk_val("host_wr_gnt", 32'(bus.host_mem_gnt), 32'd1);
    step();
    bus.xlr_owns    = 2'b11;
    bus.host_mem_wr = 1'b0;
    #1;
    chk_val("host_stall_gnt", 32'(bus.host_mem_gnt), 32'd0);
    step();
    chk_val("host_stall_rvalid0", 32'(bus.host_mem_rvalid), 32'd0);
    step();
    chk_val("host_stall_rvalid1", 32'(bus.host_mem_rvalid), 32'd0);
    bus.xlr_owns        = 2'b01;
    bus.xlr_mem_rd[0]   = 1'b1;
    bus.xlr_mem_addr[0] = 8'h05;
    #1;
    chk_val("host_release_gnt", 32'(bus.host_mem_gnt), 32'd1);
    step();
    idle();
    bus.xlr_owns = 2'b11;
    #1;
    chk_val("host_rvalid", 32'(bus.host_mem_rvalid), 32'd1);
    chk_line("host_rdata", bus.host_mem_rdata, ld);
    chk_line("parallel_xlr_rdata", bus.xlr_mem_rdata[0], lp);
    step();
    chk_val("host_rvalid_pulse", 32'(bus.host_mem_rvalid), 32'd0);
    chk_line("host_rdata_hold", bus.host_mem_rdata, ld);

    // Accelerator accesses to banks it does not own.
    bus.xlr_owns         = 2'b00;
    bus.xlr_mem_wr[0]    = 1'b1;
    bus.xlr_mem_addr[0]  = 8'h05;
    bus.xlr_mem_wdata[0] = lc;
    bus.xlr_mem_be[0]    = 32'hFFFF_FFFF;
    step();
    idle();
    chk_val("viol_one", 32'(bus.xlr_viol_cnt), 32'd1);
    bus.host_mem_req  = 1'b1;
    bus.host_mem_id   = 1'b0;
    bus.host_mem_addr = 8'h05;
    step();
    idle();
    chk_val("viol_host_rvalid", 32'(bus.host_mem_rvalid), 32'd1);
    chk_line("viol_storage0", bus.host_mem_rdata, lp);
    bus.xlr_mem_rd[0]    = 1'b1;
    bus.xlr_mem_wr[1]    = 1'b1;
    bus.xlr_mem_addr[1]  = 8'h10;
    bus.xlr_mem_wdata[1] = lc;
    bus.xlr_mem_be[1]    = 32'hFFFF_FFFF;
    step();
    idle();
    chk_val("viol_two", 32'(bus.xlr_viol_cnt), 32'd3);
    chk_line("viol_rdata_kept", bus.xlr_mem_rdata[0], lp);
    bus.host_mem_req  = 1'b1;
    bus.host_mem_id   = 1'b1;
    bus.host_mem_addr = 8'h10;
    step();
    idle();
    chk_line("viol_storage1", bus.host_mem_rdata, ld);

    bus.xlr_mem_rd = 2'b11;
    repeat (32765) @(posedge clk);
    #1;
    idle();
    chk_val("viol_fffd", 32'(bus.xlr_viol_cnt), 32'h0000_FFFD);
    bus.xlr_mem_rd = 2'b01;
    step();
    chk_val("viol_fffe", 32'(bus.xlr_viol_cnt), 32'h0000_FFFE);
    bus.xlr_mem_rd = 2'b11;
    step();
    chk_val("viol_sat_two", 32'(bus.xlr_viol_cnt), 32'h0000_FFFF);
    bus.xlr_mem_rd = 2'b01;
    step();
    idle();
    chk_val("viol_sat_hold", 32'(bus.xlr_viol_cnt), 32'h0000_FFFF);

    // Reset lands between the read request and its capture edge.
    bus.xlr_owns        = 2'b01;
    bus.xlr_mem_rd[0]   = 1'b1;
    bus.xlr_mem_addr[0] = 8'h05;
    bus.host_mem_req    = 1'b1;
    bus.host_mem_id     = 1'b1;
    bus.host_mem_addr   = 8'h10;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_line("rst_mid_xlr_rdata", bus.xlr_mem_rdata[0], zero_line);
    chk_line("rst_mid_host_rdata", bus.host_mem_rdata, zero_line);
    chk_val("rst_mid_rvalid", 32'(bus.host_mem_rvalid), 32'd0);
    chk_val("rst_mid_viol_cnt", 32'(bus.xlr_viol_cnt), 32'd0);
    idle();
    step();
    rst_n = 1'b1;
    bus.xlr_mem_rd[0] = 1'b1;
    bus.host_mem_req  = 1'b1;
    step();
    idle();
    chk_line("post_rst_xlr", bus.xlr_mem_rdata[0], lp);
    chk_val("post_rst_rvalid", 32'(bus.host_mem_rvalid), 32'd1);
    chk_line("post_rst_host", bus.host_mem_rdata, ld);

`ifdef XBOX_MEM_PARITY_EN
    bus.xlr_owns         = 2'b01;
    bus.xlr_mem_wr[0]    = 1'b1;
    bus.xlr_mem_addr[0]  = 8'h20;
    bus.xlr_mem_wdata[0] = ld;
    bus.xlr_mem_be[0]    = 32'hFFFF_FFFF;
    bus.par_inj          = 1'b1;
    step();
    idle();
    bus.xlr_mem_rd[0] = 1'b1;
    step();
    chk_val("par_err_set", 32'(bus.xlr_par_err[0]), 32'd1);
    bus.xlr_mem_addr[0] = 8'h05;
    step();
    idle();
    chk_val("par_err_clean", 32'(bus.xlr_par_err[0]), 32'd0);
    bus.xlr_owns      = 2'b00;
    bus.host_mem_req  = 1'b1;
    bus.host_mem_id   = 1'b0;
    bus.host_mem_addr = 8'h20;
    step();
    idle();
    chk_val("host_par_err", 32'(bus.host_par_err), 32'd1);
    step();
    chk_val("host_par_err_pulse", 32'(bus.host_par_err), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
